// File: rtl/avalon_mm_pkg.sv
// Shared types for the burst-capable Avalon-MM slave memory.
package avalon_mm_pkg;

  typedef enum logic [1:0] {
    OKAY        = 2'b00,
    RESERVED    = 2'b01,
    SLAVEERROR  = 2'b10,
    DECODEERROR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  // One bus transaction as seen by stimulus/monitor code, with its burst length.
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic [7:0]  burst_len;
    resp_t       response;
  } avalon_mm_seq_item;

  // A bad burstcount is reported in preference to an address range problem.
  function automatic resp_t burst_resp(input logic bad_len, input logic out_of_range);
    if (bad_len) return DECODEERROR;
    if (out_of_range) return SLAVEERROR;
    return OKAY;
  endfunction

endpackage

// File: rtl/avalon_mm_burst_mem_if.sv
// Avalon-MM burst bus bundle with master and slave views.
interface avalon_mm_burst_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) ();

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int BE = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE-1:0]         byteenable;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [BW-1:0]         burstcount;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  avalon_mm_pkg::resp_t  response;
  logic                  writeresponsevalid;

  modport master (
    output address, byteenable, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid, response, writeresponsevalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid, response, writeresponsevalid
  );

endinterface

// File: rtl/avalon_mm_lat_pipe.sv
// Read-return delay line; only the valid bits are reset so the data path stays cheap.
module avalon_mm_lat_pipe
  import avalon_mm_pkg::*;
#(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  resp_t                 in_resp,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output resp_t                 out_resp
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign out_resp  = in_resp;
  end else begin : g_shift
    logic                  valid_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    resp_t                 resp_q  [DEPTH];

    // Shift the valid flags; reset flushes any beats in flight.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      end else begin
        valid_q[0] <= in_valid;
        for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
      end
    end

    // Shift data and response alongside the valid flags.
    always_ff @(posedge clock) begin
      data_q[0] <= in_data;
      resp_q[0] <= in_resp;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        resp_q[i] <= resp_q[i-1];
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_resp  = resp_q[DEPTH-1];
  end

endmodule

// File: rtl/avalon_mm_burst_mem.sv
// Avalon-MM slave memory with bursts, pipelined read return and error responses.
module avalon_mm_burst_mem
  import avalon_mm_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int MAX_BURST    = 16,
  parameter int READ_LATENCY = 2
) (
  input logic                 clock,
  input logic                 reset,
  avalon_mm_burst_mem_if.slave bus
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int BE = DATA_WIDTH / 8;
  localparam int AB = $clog2(BE);
  localparam int MW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(READ_LATENCY + MAX_BURST) + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_WORDS);

  state_t                state_q, state_d;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] wr_idx_q, rd_idx_q;
  logic [BW-1:0]         wr_left_q, rd_issue_left_q;
  logic [CW-1:0]         rd_cyc_q;
  resp_t                 wr_resp_acc_q, rd_resp_acc_q, wr_resp_q;
  logic                  wrv_q;
  logic                  rs_valid_q;
  logic [DATA_WIDTH-1:0] rs_data_q;
  resp_t                 rs_resp_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] cmd_idx;
  logic                  bad_len;
  logic [BW-1:0]         len_eff;
  logic [ADDR_WIDTH:0]   last_idx;
  resp_t                 cmd_resp;
  logic                  waitrequest, accept_wr, accept_rd, wr_last, rd_issue;
  logic                  mem_we, rd_in_range;
  logic [ADDR_WIDTH-1:0] wr_beat_idx, rd_beat_idx;
  resp_t                 wr_burst_resp, rd_beat_resp;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;
  resp_t                 pipe_resp;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^bus.address[AB-1:0];

  // Decode the command on the bus: word index, effective length, burst-wide response.
  always_comb begin
    cmd_idx  = {{AB{1'b0}}, bus.address[ADDR_WIDTH-1:AB]};
    bad_len  = (bus.burstcount == '0) || (bus.burstcount > BW'(MAX_BURST));
    len_eff  = bad_len ? BW'(1) : bus.burstcount;
    last_idx = {1'b0, cmd_idx} + (ADDR_WIDTH+1)'(len_eff) - (ADDR_WIDTH+1)'(1);
    cmd_resp = burst_resp(bad_len, last_idx >= DEPTH_EXT);
  end

  // FSM state register; ready_q holds off commands until the first edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_wr && !wr_last) state_d = WR_BURST;
        else if (accept_rd && ((CW'(READ_LATENCY) + CW'(len_eff)) > CW'(2))) state_d = RD_BURST;
      end
      WR_BURST: if (accept_wr && wr_last) state_d = IDLE;
      RD_BURST: if (rd_cyc_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs: stall, command acceptance and the per-beat address/response selection.
  always_comb begin
    waitrequest   = !ready_q || (state_q == RD_BURST);
    accept_wr     = !waitrequest && bus.write;
    accept_rd     = !waitrequest && (state_q == IDLE) && bus.read && !bus.write;
    wr_last       = (state_q == IDLE) ? (len_eff == BW'(1)) : (wr_left_q == BW'(1));
    wr_beat_idx   = (state_q == IDLE) ? cmd_idx : wr_idx_q;
    wr_burst_resp = (state_q == IDLE) ? cmd_resp : wr_resp_acc_q;
    mem_we        = accept_wr && ({1'b0, wr_beat_idx} < DEPTH_EXT);
    rd_issue      = accept_rd || ((state_q == RD_BURST) && (rd_issue_left_q != '0));
    rd_beat_idx   = accept_rd ? cmd_idx : rd_idx_q;
    rd_beat_resp  = accept_rd ? cmd_resp : rd_resp_acc_q;
    rd_in_range   = {1'b0, rd_beat_idx} < DEPTH_EXT;
  end

  // Write burst tracking and the one-cycle write response pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_idx_q      <= '0;
      wr_left_q     <= '0;
      wr_resp_acc_q <= OKAY;
      wr_resp_q     <= OKAY;
      wrv_q         <= 1'b0;
    end else begin
      wrv_q <= accept_wr && wr_last;
      if (accept_wr) begin
        wr_idx_q      <= wr_beat_idx + ADDR_WIDTH'(1);
        wr_left_q     <= (state_q == IDLE) ? len_eff - BW'(1) : wr_left_q - BW'(1);
        wr_resp_acc_q <= wr_burst_resp;
        wr_resp_q     <= wr_burst_resp;
      end
    end
  end

  // Read burst tracking: beats still to issue and cycles until waitrequest drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_idx_q        <= '0;
      rd_issue_left_q <= '0;
      rd_cyc_q        <= '0;
      rd_resp_acc_q   <= OKAY;
      rs_valid_q      <= 1'b0;
    end else begin
      rs_valid_q <= rd_issue;
      if (accept_rd) begin
        rd_idx_q        <= cmd_idx + ADDR_WIDTH'(1);
        rd_issue_left_q <= len_eff - BW'(1);
        rd_cyc_q        <= CW'(READ_LATENCY) + CW'(len_eff) - CW'(3);
        rd_resp_acc_q   <= cmd_resp;
      end else if (state_q == RD_BURST) begin
        if (rd_issue) begin
          rd_idx_q        <= rd_idx_q + ADDR_WIDTH'(1);
          rd_issue_left_q <= rd_issue_left_q - BW'(1);
        end
        if (rd_cyc_q != '0) rd_cyc_q <= rd_cyc_q - CW'(1);
      end
    end
  end

  // Byte-masked write port; out-of-range beats never touch the array.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < BE; b++) begin
        if (bus.byteenable[b]) mem[wr_beat_idx[MW-1:0]][8*b +: 8] <= bus.writedata[8*b +: 8];
      end
    end
  end

  // Registered memory read; out-of-range beats read as zero.
  always_ff @(posedge clock) begin
    rs_data_q <= rd_in_range ? mem[rd_beat_idx[MW-1:0]] : '0;
    rs_resp_q <= rd_beat_resp;
  end

  avalon_mm_lat_pipe #(
    .DEPTH      (READ_LATENCY - 1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lat_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rs_valid_q),
    .in_data   (rs_data_q),
    .in_resp   (rs_resp_q),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_resp  (pipe_resp)
  );

  assign bus.waitrequest        = waitrequest;
  assign bus.readdatavalid      = pipe_valid;
  assign bus.readdata           = pipe_valid ? pipe_data : '0;
  assign bus.response           = pipe_valid ? pipe_resp : (wrv_q ? wr_resp_q : OKAY);
  assign bus.writeresponsevalid = wrv_q;

  // A master driving read and write together in IDLE is broken; the write is taken.
  assert property (@(posedge clock) disable iff (reset)
    !(ready_q && (state_q == IDLE) && bus.read && bus.write));

endmodule

// File: doc/avalon_mm_burst_mem.md
# avalon_mm_burst_mem

Synthesizable Avalon-MM slave memory with burst support, pipelined read return and error responses. It generalises the bench's single-beat Avalon-MM master/slave signalling to `burstcount`, `readdatavalid` and `writeresponsevalid`. It is the capture-buffer target and the burst-capable endpoint for bpfcap testbenches.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; a multiple of 8, at least 16.
- DEPTH_WORDS, 1024, number of memory words.
- MAX_BURST, 16, maximum legal burstcount.
- READ_LATENCY, 2, cycles from read accept to first beat; at least 1.

Ports (BW = $clog2(MAX_BURST)+1, BE = DATA_WIDTH/8):
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  byte address; low $clog2(BE) bits ignored.
- byteenable  in  BE  write byte mask; ignored on reads.
- read  in  1  read command.
- write  in  1  write beat.
- writedata  in  DATA_WIDTH  write data.
- burstcount  in  BW  beats; sampled on the first beat only.
- waitrequest  out  1  stall.
- readdata  out  DATA_WIDTH  read beat data.
- readdatavalid  out  1  read beat valid.
- response  out  2  valid with readdatavalid or writeresponsevalid; 00 otherwise.
- writeresponsevalid  out  1  one pulse per write burst.

## Operation
- FSM states:
  - IDLE: waitrequest=0; accepts commands.
  - WR_BURST: waitrequest=0; collects the remaining beats.
  - RD_BURST: waitrequest=1; beats are returning.
- Word index = address >> $clog2(BE). It is incremented by 1 per beat, in ADDR_WIDTH modulo arithmetic, with no wrap to 0 at DEPTH_WORDS.
- Out-of-range beat (index >= DEPTH_WORDS):
  - writes are dropped;
  - reads return readdata=0;
  - the burst response becomes 10 (SLAVEERROR).
- burstcount of 0 or greater than MAX_BURST: the command is executed as a 1-beat burst at the given address with response 11 (DECODEERROR). DECODEERROR overrides SLAVEERROR.
- Write beat: bytes with byteenable=1 are stored; all other bytes are unchanged.
- Write burst end: writeresponsevalid pulses for 1 cycle with the accumulated response.
- Read and write both high in IDLE: write wins, read is ignored, and a simulation assertion fires.
- read or write while in RD_BURST: ignored, because waitrequest=1.
- Memory array has no reset; contents survive reset.
- Reset values:
  - waitrequest=1 while reset is high; it falls on the first clock edge after release;
  - readdata=0, readdatavalid=0, response=00, writeresponsevalid=0, FSM=IDLE.
- Reset mid-burst: outstanding read beats and the write-beat count are discarded, no response is issued, and the FSM returns to IDLE.

## Timing
- Read accepted at edge N (read=1, waitrequest=0, IDLE).
  - waitrequest=1 from after edge N.
  - readdatavalid=1 in cycles N+READ_LATENCY through N+READ_LATENCY+len-1, contiguous.
  - waitrequest falls in the last beat's cycle, so a new command can be accepted at the edge ending that cycle.
- Read data reflects all writes accepted before edge N.
- Write burst, first beat at edge N:
  - the remaining len-1 beats are accepted at each later edge where write=1; gaps are allowed;
  - writeresponsevalid is high in the cycle after the last beat edge;
  - a new command can be accepted in that same cycle.
- Single-beat write: writeresponsevalid in cycle N+1.

## Structure
- avalon_mm_pkg holds:
  - resp_t enum: OKAY=2'b00, RESERVED=2'b01, SLAVEERROR=2'b10, DECODEERROR=2'b11;
  - avalon_mm_seq_item, extended with burst_len.
- Sub-module avalon_mm_lat_pipe (depth READ_LATENCY-1, where depth 0 is a wire). It is a shift register carrying {valid, data, resp} from the registered memory read to the outputs. It resets valid only.

## Test plan
- Reset check: assert reset mid-cycle, asynchronously → outputs take their reset values immediately; waitrequest=1 until the first edge after release.
- Single write then read:
  - stimulus: write 0xDEADBEEF to address 0x10 with byteenable=1111, then read address 0x10;
  - required: writeresponsevalid one cycle after the write with response 00;
  - required: readdatavalid exactly READ_LATENCY cycles after the read accept, readdata=0xDEADBEEF, response 00.
- Partial write: write 0x11223344 with byteenable=0101 to address 0x10 (preloaded 0xDEADBEEF) → read returns 0xDE22BE44.
- Burst write and read:
  - stimulus: 4-beat write at address 0x0 with data 1,2,3,4 and a 2-cycle gap before beat 3, then a 4-beat read at address 0x0;
  - required: readdatavalid high for 4 contiguous cycles returning 1,2,3,4;
  - required: waitrequest=1 for the whole read return.
- Range errors:
  - 2-beat read starting at the last word → beats return {data, 0}, both with response 10;
  - burstcount=0 → one beat with response 11;
  - burstcount=MAX_BURST+1 → one beat with response 11.
- Reset during a read: assert reset during beat 2 of an 8-beat read → no further readdatavalid after reset; the next read completes normally with the memory intact.
